// File: rtl/cut_sig_sweeper.sv
// ============================================================================
// Module      : cut_sig_sweeper
// Description : Drives exhaustive or LFSR vectors into a CUT and folds the
//               delayed responses into a MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cut_sig_sweeper #(
    parameter int               N_IN  = 6,
    parameter int               N_OUT = 6,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter int               LAT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [15:0]       seed_i,
    input  logic [15:0]       n_vec_i,
    output logic [N_IN-1:0]   cut_in_o,
    input  logic [N_OUT-1:0]  cut_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SIG_W-1:0]  signature_o,
    output logic [16:0]       vec_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [15:0]       lfsr_q;
    logic [16:0]       n_tot_q;
    logic [16:0]       sent_q;
    logic [N_IN-1:0]   cut_in_q;
    logic [LAT:0]      vld_q;
    logic [SIG_W-1:0]  sig_q;
    logic [16:0]       vec_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [15:0]       w_seed;
    logic [16:0]       w_n;
    logic [15:0]       w_lfsr_nxt;
    logic [SIG_W-1:0]  w_sig_d;
    logic              w_cap;

    // A zero seed would lock the LFSR at zero forever.
    assign w_seed     = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    assign w_n        = mode_i ? {1'b0, n_vec_i} : (17'd1 << N_IN);
    assign w_lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign w_cap      = vld_q[LAT];
    assign w_sig_d    = {sig_q[SIG_W-2:0], 1'b0}
                      ^ (sig_q[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(cut_out_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            lfsr_q    <= 16'h0000;
            n_tot_q   <= 17'd0;
            sent_q    <= 17'd0;
            cut_in_q  <= '0;
            vld_q     <= '0;
            sig_q     <= '0;
            vec_cnt_q <= 17'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            vld_q[0] <= 1'b0;
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end

            // The valid bit at stage LAT marks the cycle whose response is due.
            if (w_cap) begin
                sig_q     <= w_sig_d;
                vec_cnt_q <= vec_cnt_q + 17'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        lfsr_q    <= w_seed;
                        n_tot_q   <= w_n;
                        sent_q    <= 17'd1;
                        sig_q     <= '1;
                        vec_cnt_q <= 17'd0;
                        busy_q    <= 1'b1;
                        cut_in_q  <= mode_i ? w_seed[N_IN-1:0] : '0;
                        if (w_n == 17'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_DRIVE;
                            vld_q[0] <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (sent_q == n_tot_q) begin
                        state_q <= S_DRAIN;
                    end else begin
                        sent_q   <= sent_q + 17'd1;
                        vld_q[0] <= 1'b1;
                        if (mode_q) begin
                            lfsr_q   <= w_lfsr_nxt;
                            cut_in_q <= w_lfsr_nxt[N_IN-1:0];
                        end else begin
                            cut_in_q <= cut_in_q + N_IN'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (vld_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cut_in_o    = cut_in_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign signature_o = sig_q;
    assign vec_count_o = vec_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cut_sig_sweeper.sv
// ============================================================================
// Module      : tb_cut_sig_sweeper
// Description : Directed-vector bench for cut_sig_sweeper in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cut_sig_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start_ab;
    logic        start_c;
    logic        mode_c;
    logic [15:0] seed_c;
    logic [15:0] nvec_c;

    logic [1:0]  cut_in_a, cut_in_b;
    logic        cut_out_a, cut_out_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [7:0]  sig_a, sig_b;
    logic [16:0] cnt_a, cnt_b;
    logic        and_r1, and_r2;

    logic [5:0]  cut_in_c;
    logic [5:0]  cut_out_c;
    logic        busy_c, done_c;
    logic [31:0] sig_c;
    logic [16:0] cnt_c;

    int n_cmp = 0;
    int n_err = 0;
    int n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cut_out_a = cut_in_a[0] & cut_in_a[1];
    assign cut_out_b = and_r2;
    assign cut_out_c = cut_in_c ^ 6'h2A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_r1 <= 1'b0;
            and_r2 <= 1'b0;
        end else begin
            and_r1 <= cut_in_b[0] & cut_in_b[1];
            and_r2 <= and_r1;
        end
    end

    cut_sig_sweeper #(.N_IN(2), .N_OUT(1), .SIG_W(8), .POLY(8'h07), .LAT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_ab), .mode_i(1'b0),
        .seed_i(16'h0000), .n_vec_i(16'h0000), .cut_in_o(cut_in_a),
        .cut_out_i(cut_out_a), .busy_o(busy_a), .done_o(done_a),
        .signature_o(sig_a), .vec_count_o(cnt_a)
    );

    cut_sig_sweeper #(.N_IN(2), .N_OUT(1), .SIG_W(8), .POLY(8'h07), .LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_ab), .mode_i(1'b0),
        .seed_i(16'h0000), .n_vec_i(16'h0000), .cut_in_o(cut_in_b),
        .cut_out_i(cut_out_b), .busy_o(busy_b), .done_o(done_b),
        .signature_o(sig_b), .vec_count_o(cnt_b)
    );

    cut_sig_sweeper u_dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .mode_i(mode_c),
        .seed_i(seed_c), .n_vec_i(nvec_c), .cut_in_o(cut_in_c),
        .cut_out_i(cut_out_c), .busy_o(busy_c), .done_o(done_c),
        .signature_o(sig_c), .vec_count_o(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start_ab = 1'b0;
        start_c  = 1'b0;
        mode_c   = 1'b0;
        seed_c   = 16'h0000;
        nvec_c   = 16'h0000;
        repeat (2) tick();
        rst_n = 1'b1;

        chk("rst_cut_a",  32'(cut_in_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a),   32'h0);
        chk("rst_done_a", 32'(done_a),   32'h0);
        chk("rst_sig_a",  32'(sig_a),    32'h0);
        chk("rst_cnt_a",  32'(cnt_a),    32'h0);
        chk("rst_sig_c",  sig_c,         32'h0);

        // Exhaustive sweep on the LAT=0 and LAT=2 instances in parallel.
        start_ab = 1'b1;
        tick();                                         // E0
        start_ab = 1'b0;
        chk("e0_cut_a",  32'(cut_in_a), 32'h0);
        chk("e0_busy_a", 32'(busy_a),   32'h1);
        chk("e0_sig_a",  32'(sig_a),    32'hFF);
        chk("e0_cnt_a",  32'(cnt_a),    32'h0);
        tick();                                         // E1
        chk("e1_cut_a",  32'(cut_in_a), 32'h1);
        start_ab = 1'b1;
        tick();                                         // E2, start mid-sweep
        start_ab = 1'b0;
        chk("e2_cut_a",  32'(cut_in_a), 32'h2);
        chk("e2_busy_b", 32'(busy_b),   32'h1);
        tick();                                         // E3
        chk("e3_cut_a",  32'(cut_in_a), 32'h3);
        tick();                                         // E4
        chk("e4_cut_hold_a", 32'(cut_in_a), 32'h3);
        chk("e4_done_a",     32'(done_a),   32'h0);
        chk("e4_busy_b",     32'(busy_b),   32'h1);
        tick();                                         // E5
        chk("e5_done_a", 32'(done_a), 32'h1);
        chk("e5_sig_a",  32'(sig_a),  32'hDC);
        chk("e5_cnt_a",  32'(cnt_a),  32'h4);
        chk("e5_busy_b", 32'(busy_b), 32'h1);
        chk("e5_done_b", 32'(done_b), 32'h0);
        start_ab = 1'b1;                                // start on a's done cycle
        tick();                                         // E6
        start_ab = 1'b0;
        chk("e6_done_a", 32'(done_a), 32'h0);
        chk("e6_busy_a", 32'(busy_a), 32'h0);
        chk("e6_done_b", 32'(done_b), 32'h0);
        chk("e6_busy_b", 32'(busy_b), 32'h1);
        tick();                                         // E7
        chk("e7_done_b", 32'(done_b), 32'h1);
        chk("e7_sig_b",  32'(sig_b),  32'hDC);
        chk("e7_cnt_b",  32'(cnt_b),  32'h4);
        chk("e7_busy_a", 32'(busy_a), 32'h0);
        tick();                                         // E8
        chk("e8_done_b", 32'(done_b), 32'h0);
        chk("e8_busy_b", 32'(busy_b), 32'h0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a || done_b || busy_a || busy_b) n_done++;
        end
        chk("no_extra_activity", 32'(n_done), 32'h0);
        chk("sig_a_held", 32'(sig_a), 32'hDC);

        // Asynchronous reset in the middle of DRIVE.
        start_ab = 1'b1;
        tick();
        start_ab = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cut_a",  32'(cut_in_a), 32'h0);
        chk("arst_busy_a", 32'(busy_a),   32'h0);
        chk("arst_sig_a",  32'(sig_a),    32'h0);
        chk("arst_cnt_a",  32'(cnt_a),    32'h0);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_a || done_b) n_done++;
        end
        chk("arst_no_done", 32'(n_done), 32'h0);

        start_ab = 1'b1;
        tick();                                         // E0
        start_ab = 1'b0;
        repeat (4) tick();                              // E1..E4
        chk("re_e4_done_a", 32'(done_a), 32'h0);
        tick();                                         // E5
        chk("re_done_a", 32'(done_a), 32'h1);
        chk("re_sig_a",  32'(sig_a),  32'hDC);
        chk("re_cnt_a",  32'(cnt_a),  32'h4);
        repeat (4) tick();

        // LFSR mode on the default-parameter instance.
        mode_c  = 1'b1;
        seed_c  = 16'h0001;
        nvec_c  = 16'd3;
        start_c = 1'b1;
        tick();                                         // E0
        start_c = 1'b0;
        chk("l1_cut0", 32'(cut_in_c), 32'h01);
        chk("l1_sig0", sig_c,         32'hFFFFFFFF);
        tick();
        chk("l1_cut1", 32'(cut_in_c), 32'h02);
        tick();
        chk("l1_cut2", 32'(cut_in_c), 32'h04);
        tick();                                         // E3
        chk("l1_hold", 32'(cut_in_c), 32'h04);
        chk("l1_done_early", 32'(done_c), 32'h0);
        tick();                                         // E4
        chk("l1_done", 32'(done_c), 32'h1);
        chk("l1_cnt",  32'(cnt_c),  32'h3);
        repeat (2) tick();

        seed_c  = 16'h0000;
        nvec_c  = 16'd1;
        start_c = 1'b1;
        tick();                                         // E0
        start_c = 1'b0;
        chk("l2_cut0", 32'(cut_in_c), 32'h01);
        tick();
        chk("l2_done_early", 32'(done_c), 32'h0);
        tick();                                         // E2
        chk("l2_done", 32'(done_c), 32'h1);
        chk("l2_cnt",  32'(cnt_c),  32'h1);
        repeat (2) tick();

        nvec_c  = 16'd0;
        start_c = 1'b1;
        tick();                                         // E0
        start_c = 1'b0;
        chk("l3_done", 32'(done_c), 32'h1);
        chk("l3_sig",  sig_c,       32'hFFFFFFFF);
        chk("l3_cnt",  32'(cnt_c),  32'h0);
        tick();
        chk("l3_done_off", 32'(done_c), 32'h0);
        chk("l3_busy_off", 32'(busy_c), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
